// File: rtl/mem_stage_resp_ctl_pkg.sv
// Shared widths, cancel-counter sizing helper and response-routing type
// for the MEM-stage response controller.
package mem_stage_resp_ctl_pkg;

    // Stage bus widths (EXE->MEM and MEM->WB carry the same payload).
    localparam int LineExToNextBusWidth = 260;
    localparam int LineMmToNextBusWidth = 260;

    // Data-cache read data width.
    localparam int MEM_DATA_W = 32;

    // Default number of orphaned responses that can be tracked.
    localparam int MEM_MAX_CANCEL = 3;

    // Width needed to count 0..max_cancel.
    function automatic int cancel_cnt_width(input int max_cancel);
        return $clog2(max_cancel + 1);
    endfunction

    // Where an incoming data_ok goes.
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_DROP = 2'd1,
        RESP_SLOT = 2'd2
    } resp_route_e;

endpackage

// File: rtl/mem_stage_resp_ctl_cancel_cnt.sv
// Saturating counter of cache responses whose owners were flushed.
// Counts up by 0..2 on a flush and down by 1 per dropped response.
module mem_resp_cancel_cnt
    import mem_stage_resp_ctl_pkg::*;
#(
    parameter int MAX_CANCEL = MEM_MAX_CANCEL,
    parameter int CNT_W      = cancel_cnt_width(MAX_CANCEL)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_dec,
    input  logic [1:0] i_inc,
    output logic       o_zero,
    output logic       o_block
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W+1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next count: consume the dropped response first, then add the new orphans.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_sum = {2'b00, r_cnt} + {{CNT_W{1'b0}}, i_inc};
        if (i_dec && (r_cnt != '0)) begin
            w_sum = w_sum - (CNT_W+2)'(1);
        end
        w_cnt_nxt = w_sum[CNT_W-1:0];
        if (w_sum > (CNT_W+2)'(MAX_CANCEL)) begin
            w_cnt_nxt = CNT_W'(MAX_CANCEL);
        end
    end

    // Counter register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_zero  = (r_cnt == '0);
    assign o_block = (r_cnt > CNT_W'(MAX_CANCEL - 2));

endmodule

// File: rtl/mem_stage_resp_ctl.sv
// MEM-stage slot with cache response tracking: waits for data_ok, buffers
// read data while WB stalls, and drops responses orphaned by a flush.
module mem_stage_resp_ctl
    import mem_stage_resp_ctl_pkg::*;
#(
    parameter int PAYLOAD_W  = LineExToNextBusWidth,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int MAX_CANCEL = MEM_MAX_CANCEL,
    parameter int CNT_W      = cancel_cnt_width(MAX_CANCEL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pre_to_now_valid_i,
    input  logic [PAYLOAD_W-1:0] pre_to_ibus,
    input  logic                 pre_req_issued_i,
    input  logic                 pre_req_pending_i,
    output logic                 now_allowin_o,
    input  logic                 excep_flush_i,
    input  logic                 data_ok_i,
    input  logic [DATA_W-1:0]    rdata_i,
    input  logic                 next_allowin_i,
    output logic                 now_to_next_valid_o,
    output logic [PAYLOAD_W-1:0] to_next_obus,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 req_block_o
);

    logic                 r_valid;
    logic                 r_pending;
    logic                 r_rbuf_valid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [DATA_W-1:0]    r_rbuf;

    resp_route_e          w_route;
    logic                 w_cnt_zero;
    logic                 w_cnt_block;
    logic                 w_drop;
    logic                 w_slot_hit;
    logic                 w_ready_go;
    logic                 w_slot_write;
    logic                 w_slot_leave;
    logic                 w_capture;
    logic [1:0]           w_cnt_inc;

    // Route each response: drop while orphans are outstanding, else it is the slot's.
    always_comb begin
        w_route = RESP_NONE;
        if (data_ok_i) begin
            w_route = w_cnt_zero ? RESP_SLOT : RESP_DROP;
        end
    end

    assign w_drop     = (w_route == RESP_DROP);
    assign w_slot_hit = (w_route == RESP_SLOT);

    // Handshake: a live slot response releases the slot in the same cycle.
    assign w_ready_go          = ~r_pending | r_rbuf_valid | w_slot_hit;
    assign now_allowin_o       = ~r_valid | (w_ready_go & next_allowin_i);
    assign now_to_next_valid_o = r_valid & w_ready_go & ~excep_flush_i;
    assign w_slot_write        = pre_to_now_valid_i & now_allowin_o & ~excep_flush_i;
    assign w_slot_leave        = now_to_next_valid_o & next_allowin_i;
    assign w_capture           = w_slot_hit & r_valid & r_pending & ~w_slot_leave & ~excep_flush_i;

    // On a flush, the slot's unanswered request and any EXE request become orphans.
    assign w_cnt_inc = excep_flush_i
                     ? ({1'b0, r_pending & ~w_slot_hit} + {1'b0, pre_req_pending_i})
                     : 2'b00;

    mem_resp_cancel_cnt #(
        .MAX_CANCEL (MAX_CANCEL),
        .CNT_W      (CNT_W)
    ) u_cancel_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_dec   (w_drop),
        .i_inc   (w_cnt_inc),
        .o_zero  (w_cnt_zero),
        .o_block (w_cnt_block)
    );

    // Stop new requests when the counter is near full, or when a flush of the
    // waiting slot could push it over while orphans are still outstanding.
    assign req_block_o = w_cnt_block | (r_pending & r_valid & ~w_ready_go & ~w_cnt_zero);

    // Slot occupancy, pending flag, buffer flag and payload latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pending    <= 1'b0;
            r_rbuf_valid <= 1'b0;
            r_payload    <= '0;
        end else if (excep_flush_i) begin
            r_valid      <= 1'b0;
            r_pending    <= 1'b0;
            r_rbuf_valid <= 1'b0;
        end else if (w_slot_write) begin
            r_valid      <= 1'b1;
            r_pending    <= pre_req_issued_i;
            r_rbuf_valid <= 1'b0;
            r_payload    <= pre_to_ibus;
        end else if (w_slot_leave) begin
            r_valid      <= 1'b0;
            r_pending    <= 1'b0;
            r_rbuf_valid <= 1'b0;
        end else if (w_capture) begin
            r_pending    <= 1'b0;
            r_rbuf_valid <= 1'b1;
        end
    end

    // Hold the slot's read data while WB is stalled.
    // NOTE: r_rbuf is only observed while r_rbuf_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_rbuf <= rdata_i;
        end
    end

    assign to_next_obus = r_payload;
    assign rdata_o      = r_rbuf_valid ? r_rbuf : rdata_i;

    // A response with no orphan to cancel must belong to a waiting slot.
    a_resp_has_owner: assert property (@(posedge clk) disable iff (rst)
        !(data_ok_i && w_cnt_zero && !(r_valid && r_pending)));

endmodule

// File: tb/tb_mem_stage_resp_ctl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic checked against a request-ownership queue model.
module tb_mem_stage_resp_ctl;
    import mem_stage_resp_ctl_pkg::*;

    localparam int PW   = LineExToNextBusWidth;
    localparam int DW   = MEM_DATA_W;
    localparam int MAXC = 3;
    localparam int NRND = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          pre_to_now_valid_i;
    logic [PW-1:0] pre_to_ibus;
    logic          pre_req_issued_i;
    logic          pre_req_pending_i;
    logic          now_allowin_o;
    logic          excep_flush_i;
    logic          data_ok_i;
    logic [DW-1:0] rdata_i;
    logic          next_allowin_i;
    logic          now_to_next_valid_o;
    logic [PW-1:0] to_next_obus;
    logic [DW-1:0] rdata_o;
    logic          req_block_o;

    mem_stage_resp_ctl #(
        .PAYLOAD_W  (PW),
        .DATA_W     (DW),
        .MAX_CANCEL (MAXC),
        .CNT_W      (2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pre_to_now_valid_i  (pre_to_now_valid_i),
        .pre_to_ibus         (pre_to_ibus),
        .pre_req_issued_i    (pre_req_issued_i),
        .pre_req_pending_i   (pre_req_pending_i),
        .now_allowin_o       (now_allowin_o),
        .excep_flush_i       (excep_flush_i),
        .data_ok_i           (data_ok_i),
        .rdata_i             (rdata_i),
        .next_allowin_i      (next_allowin_i),
        .now_to_next_valid_o (now_to_next_valid_o),
        .to_next_obus        (to_next_obus),
        .rdata_o             (rdata_o),
        .req_block_o         (req_block_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_p(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rand_pay();
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < PW; i += 32) p = (p << 32) | PW'($urandom);
        return p;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        pre_to_now_valid_i = 1'b0;
        pre_to_ibus        = '0;
        pre_req_issued_i   = 1'b0;
        pre_req_pending_i  = 1'b0;
        excep_flush_i      = 1'b0;
        data_ok_i          = 1'b0;
        rdata_i            = '0;
        next_allowin_i     = 1'b1;
    endtask

    task automatic offer(input logic [PW-1:0] pay, input logic issued);
        pre_to_now_valid_i = 1'b1;
        pre_to_ibus        = pay;
        pre_req_issued_i   = issued;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Random-phase model: queue of outstanding request owners (-1 = orphan).
    int            q[$];
    logic          s_valid, s_req, s_rcvd;
    int            s_id;
    logic [PW-1:0] s_pay;
    logic [DW-1:0] s_data;
    logic          e_valid, e_req;
    int            e_id;
    logic [PW-1:0] e_pay;
    int            next_id;
    int            orph;
    logic          flush, nall, dok, can_resp, slot_resp, ready, leave, write;
    logic          exp_allow, exp_vo, exp_block;
    logic [DW-1:0] rd;
    logic [PW-1:0] p0, p1, p2, p3;

    initial begin
        idle_inputs();
        rst = 1'b1;
        do_reset();

        // Reset state.
        settle();
        check_b("rst_allowin", now_allowin_o, 1'b1);
        check_b("rst_valid_o", now_to_next_valid_o, 1'b0);
        check_b("rst_block", req_block_o, 1'b0);
        check_p("rst_obus", to_next_obus, '0);
        check_d("rst_rdata", rdata_o, '0);

        // Load; data_ok three cycles after the slot fills; WB ready.
        p0 = rand_pay();
        offer(p0, 1'b1);
        settle();
        check_b("ld_allowin", now_allowin_o, 1'b1);
        tick(); idle_inputs(); settle();
        check_b("ld_wait1_valid_o", now_to_next_valid_o, 1'b0);
        check_b("ld_wait1_allowin", now_allowin_o, 1'b0);
        tick(); settle();
        check_b("ld_wait2_valid_o", now_to_next_valid_o, 1'b0);
        tick(); data_ok_i = 1'b1; rdata_i = 32'hDEADBEEF; settle();
        check_b("ld_dok_valid_o", now_to_next_valid_o, 1'b1);
        check_d("ld_dok_rdata", rdata_o, 32'hDEADBEEF);
        check_p("ld_dok_obus", to_next_obus, p0);
        check_b("ld_dok_allowin", now_allowin_o, 1'b1);
        tick(); idle_inputs(); settle();
        check_b("ld_after_valid_o", now_to_next_valid_o, 1'b0);

        // Load whose response arrives while WB stalls for two cycles.
        p1 = rand_pay();
        offer(p1, 1'b1); next_allowin_i = 1'b0;
        tick(); idle_inputs(); next_allowin_i = 1'b0;
        data_ok_i = 1'b1; rdata_i = 32'h12345678; settle();
        check_b("buf_dok_valid_o", now_to_next_valid_o, 1'b1);
        check_b("buf_dok_allowin", now_allowin_o, 1'b0);
        tick(); data_ok_i = 1'b0; rdata_i = 32'hFFFFFFFF; settle();
        check_d("buf_hold_rdata", rdata_o, 32'h12345678);
        check_b("buf_hold_valid_o", now_to_next_valid_o, 1'b1);
        p2 = rand_pay();
        tick(); next_allowin_i = 1'b1; offer(p2, 1'b1); settle();
        check_d("buf_release_rdata", rdata_o, 32'h12345678);
        check_b("buf_release_allowin", now_allowin_o, 1'b1);
        tick(); idle_inputs(); data_ok_i = 1'b1; rdata_i = 32'hCAFEF00D; settle();
        check_b("buf_next_valid_o", now_to_next_valid_o, 1'b1);
        check_d("buf_next_rdata", rdata_o, 32'hCAFEF00D);
        check_p("buf_next_obus", to_next_obus, p2);
        tick(); idle_inputs(); settle();
        check_b("buf_after_valid_o", now_to_next_valid_o, 1'b0);

        // Flush with the slot waiting and an EXE request outstanding: two orphans.
        offer(rand_pay(), 1'b1);
        tick(); idle_inputs(); excep_flush_i = 1'b1; pre_req_pending_i = 1'b1; settle();
        check_b("fl_valid_o", now_to_next_valid_o, 1'b0);
        tick(); idle_inputs(); settle();
        check_b("fl_block_cnt2", req_block_o, 1'b1);
        check_b("fl_allowin", now_allowin_o, 1'b1);
        tick(); data_ok_i = 1'b1; rdata_i = 32'h1; settle();
        check_b("fl_drop1_valid_o", now_to_next_valid_o, 1'b0);
        check_b("fl_drop1_block", req_block_o, 1'b1);
        tick(); data_ok_i = 1'b1; rdata_i = 32'h2; settle();
        check_b("fl_drop2_valid_o", now_to_next_valid_o, 1'b0);
        tick(); idle_inputs(); settle();
        check_b("fl_cnt0_block", req_block_o, 1'b0);

        // Flush in the same cycle as the slot's own response.
        offer(rand_pay(), 1'b1);
        tick(); idle_inputs(); excep_flush_i = 1'b1; data_ok_i = 1'b1; rdata_i = 32'h55; settle();
        check_b("flhit_valid_o", now_to_next_valid_o, 1'b0);
        p3 = rand_pay();
        tick(); idle_inputs(); offer(p3, 1'b1); settle();
        check_b("flhit_block", req_block_o, 1'b0);
        check_b("flhit_allowin", now_allowin_o, 1'b1);
        tick(); idle_inputs(); data_ok_i = 1'b1; rdata_i = 32'hA5A5A5A5; settle();
        check_b("flhit_next_valid_o", now_to_next_valid_o, 1'b1);
        check_d("flhit_next_rdata", rdata_o, 32'hA5A5A5A5);
        check_p("flhit_next_obus", to_next_obus, p3);
        tick(); idle_inputs(); settle();

        // Stores without a request stream back to back.
        p0 = rand_pay(); p1 = rand_pay(); p2 = rand_pay(); p3 = rand_pay();
        offer(p0, 1'b0); settle();
        check_b("st0_allowin", now_allowin_o, 1'b1);
        tick(); offer(p1, 1'b0); settle();
        check_b("st1_allowin", now_allowin_o, 1'b1);
        check_b("st1_valid_o", now_to_next_valid_o, 1'b1);
        check_p("st1_obus", to_next_obus, p0);
        tick(); offer(p2, 1'b0); settle();
        check_b("st2_allowin", now_allowin_o, 1'b1);
        check_p("st2_obus", to_next_obus, p1);
        tick(); offer(p3, 1'b0); settle();
        check_b("st3_allowin", now_allowin_o, 1'b1);
        check_p("st3_obus", to_next_obus, p2);
        tick(); idle_inputs(); settle();
        check_b("st4_valid_o", now_to_next_valid_o, 1'b1);
        check_p("st4_obus", to_next_obus, p3);
        tick(); settle();
        check_b("st5_valid_o", now_to_next_valid_o, 1'b0);

        // Reset with two orphans outstanding and a valid slot.
        offer(rand_pay(), 1'b1);
        tick(); idle_inputs(); excep_flush_i = 1'b1; pre_req_pending_i = 1'b1;
        tick(); idle_inputs(); offer(rand_pay(), 1'b0); settle();
        check_b("mrst_pre_block", req_block_o, 1'b1);
        tick(); idle_inputs(); next_allowin_i = 1'b0; settle();
        check_b("mrst_pre_valid_o", now_to_next_valid_o, 1'b1);
        rst = 1'b1;
        tick(); rst = 1'b0; idle_inputs(); settle();
        check_b("mrst_valid_o", now_to_next_valid_o, 1'b0);
        check_b("mrst_block", req_block_o, 1'b0);
        check_b("mrst_allowin", now_allowin_o, 1'b1);

        // Randomized traffic against the ownership-queue model.
        do_reset();
        q.delete();
        s_valid = 0; s_req = 0; s_rcvd = 0; s_id = -1; s_pay = '0; s_data = '0;
        e_valid = 0; e_req = 0; e_id = -1; e_pay = '0;
        next_id = 0;
        for (int cyc = 0; cyc < NRND; cyc++) begin
            flush    = ($urandom_range(0, 15) == 0);
            nall     = ($urandom_range(0, 9) < 7);
            can_resp = (q.size() > 0) && ((q[0] < 0) || (s_valid && (q[0] == s_id)));
            dok      = can_resp && ($urandom_range(0, 1) == 1);
            rd       = $urandom;

            pre_to_now_valid_i = e_valid;
            pre_to_ibus        = e_pay;
            pre_req_issued_i   = e_valid & e_req;
            pre_req_pending_i  = e_valid & e_req;
            excep_flush_i      = flush;
            data_ok_i          = dok;
            rdata_i            = rd;
            next_allowin_i     = nall;

            orph = 0;
            foreach (q[i]) if (q[i] < 0) orph++;
            slot_resp = dok && (q[0] >= 0);
            ready     = !s_req || s_rcvd || slot_resp;
            exp_allow = !s_valid || (ready && nall);
            exp_vo    = s_valid && ready && !flush;
            exp_block = (orph > MAXC - 2) || (s_valid && s_req && !ready && (orph != 0));

            settle();
            check_b("rnd_allowin", now_allowin_o, exp_allow);
            check_b("rnd_valid_o", now_to_next_valid_o, exp_vo);
            check_b("rnd_block", req_block_o, exp_block);
            if (exp_vo) begin
                check_p("rnd_obus", to_next_obus, s_pay);
                if (s_req) check_d("rnd_rdata", rdata_o, s_rcvd ? s_data : rd);
            end

            leave = exp_vo && nall;
            write = e_valid && exp_allow && !flush;
            if (dok) begin
                if ((q[0] >= 0) && !leave) begin
                    s_rcvd = 1'b1;
                    s_data = rd;
                end
                void'(q.pop_front());
            end
            if (flush) begin
                s_valid = 1'b0;
                e_valid = 1'b0;
                foreach (q[i]) q[i] = -1;
            end else if (write) begin
                s_valid = 1'b1; s_id = e_id; s_pay = e_pay; s_req = e_req; s_rcvd = 1'b0;
                e_valid = 1'b0;
            end else if (leave) begin
                s_valid = 1'b0;
            end
            if (!flush && !e_valid && ($urandom_range(0, 9) < 6)) begin
                e_valid = 1'b1;
                e_id    = next_id;
                next_id++;
                e_pay   = rand_pay();
                e_req   = !exp_block && ($urandom_range(0, 2) != 0);
                if (e_req) q.push_back(e_id);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
